// File: rtl/parity_seq_gen.sv
// parity_seq_gen: emits a run of WIDTH-bit values that all share one parity.
// A start command programs the parity, seed and length. Values leave under a
// valid/ready handshake, and a one-cycle done pulse closes each run.
module parity_seq_gen #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             want_even,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] a,
    output logic             is_even,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic             r_is_even;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_remaining;

    // First value of a run: the seed with its LSB forced to the requested parity.
    function automatic logic [WIDTH-1:0] f_first_value(input logic [WIDTH-1:0] sd,
                                                       input logic             even);
        return {sd[WIDTH-1:1], ~even};
    endfunction

    // Next value: +2 wraps modulo 2^WIDTH and leaves the LSB (the parity) untouched.
    function automatic logic [WIDTH-1:0] f_next_value(input logic [WIDTH-1:0] cur);
        return cur + WIDTH'(2);
    endfunction

    // Sequencer FSM; every output is a register updated together with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_is_even   <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (count != '0) begin
                            r_remaining <= count;
                            r_a         <= f_first_value(seed, want_even);
                            // is_even mirrors ~a[0], which the load sets to want_even
                            r_is_even   <= want_even;
                            r_out_valid <= 1'b1;
                            r_state     <= S_EMIT;
                        end else begin
                            // empty run: skip straight to the done pulse
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_a         <= f_next_value(r_a);
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign a         = r_a;
    assign is_even   = r_is_even;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_parity_seq_gen.sv
// Bench for parity_seq_gen: directed scenarios plus randomized runs. Expected
// values come from a closed-form model of each run (base + 2*i mod 2^WIDTH).
module tb_parity_seq_gen;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             want_even;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] count;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] a;
    logic             is_even;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    // value of a the model expects to be held while idle
    int last_a = 0;

    parity_seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .want_even (want_even),
        .seed      (seed),
        .count     (count),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .a         (a),
        .is_even   (is_even),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bits(input string tag, input logic [WIDTH-1:0] obs, input int exp);
        total++;
        assert (obs === WIDTH'(exp) && !$isunknown(obs)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete command: start, drain all values, done pulse, back to idle.
    task automatic run_seq(input bit we, input int sd, input int cnt,
                           input int stall_first, input bit rnd_ready, input bit poke_start);
        int base;
        int exp_v;
        int final_a;
        int idx;
        int cyc;
        int stalls;
        base   = (sd & ~1) | (we ? 0 : 1);
        idx    = 0;
        cyc    = 0;
        stalls = 0;
        want_even = we;
        seed      = WIDTH'(sd);
        count     = CNT_W'(cnt);
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        // scramble command inputs: they must only matter at the accepted start
        want_even = 1'($urandom);
        seed      = WIDTH'($urandom);
        count     = CNT_W'($urandom);
        while (idx < cnt) begin
            exp_v = (base + 2 * idx) % (1 << WIDTH);
            chk("emit_valid", int'(out_valid), 1);
            chk_bits("emit_a", a, exp_v);
            chk("emit_is_even", int'(is_even), int'(we));
            chk("emit_busy", int'(busy), 1);
            chk("emit_done", int'(done), 0);
            if (cyc < stall_first)
                out_ready = 1'b0;
            else if (rnd_ready && stalls < 3)
                out_ready = 1'($urandom_range(0, 1));
            else
                out_ready = 1'b1;
            if (out_ready) stalls = 0;
            else stalls++;
            if (poke_start && cyc == 1) begin
                start     = 1'b1;
                seed      = WIDTH'(9);
                want_even = 1'b0;
                count     = CNT_W'(5);
            end else begin
                start = 1'b0;
            end
            step();
            if (out_ready) idx++;
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'($urandom);
        final_a   = (cnt == 0) ? last_a : (base + 2 * cnt) % (1 << WIDTH);
        chk("done_valid", int'(out_valid), 0);
        chk("done_pulse", int'(done), 1);
        chk("done_busy", int'(busy), 1);
        chk_bits("done_a_hold", a, final_a);
        chk("done_is_even", int'(is_even), (final_a & 1) ? 0 : 1);
        step();
        chk("idle_done", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_valid", int'(out_valid), 0);
        chk_bits("idle_a_hold", a, final_a);
        step();
        chk("idle2_busy", int'(busy), 0);
        chk("idle2_valid", int'(out_valid), 0);
        chk_bits("idle2_a_hold", a, final_a);
        last_a = final_a;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        want_even = 1'b0;
        seed      = '0;
        count     = '0;
        out_ready = 1'b0;
        step();
        step();
        chk_bits("rst_a", a, 0);
        chk("rst_is_even", int'(is_even), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        step();
        chk("post_rst_busy", int'(busy), 0);
        last_a = 0;

        // basic even run: 4, 6, 8
        run_seq(1'b1, 5, 3, 0, 1'b0, 1'b0);
        // odd run with wrap: 13, 15, 1, 3
        run_seq(1'b0, 13, 4, 0, 1'b0, 1'b0);
        // backpressure: ready low for the first two cycles of valid data
        run_seq(1'b1, 0, 2, 2, 1'b0, 1'b0);
        // zero-length command
        run_seq(1'b1, 7, 0, 0, 1'b0, 1'b0);
        // start pulsed during EMIT must be ignored
        run_seq(1'b1, 5, 3, 0, 1'b0, 1'b1);
        // even run with wrap through 0
        run_seq(1'b1, 12, 4, 0, 1'b0, 1'b0);

        // reset after the second value of a count=5 run
        want_even = 1'b1;
        seed      = WIDTH'(5);
        count     = CNT_W'(5);
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        chk_bits("mid_a0", a, 4);
        step();
        chk_bits("mid_a1", a, 6);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_bits("mid_rst_a", a, 0);
        chk("mid_rst_is_even", int'(is_even), 1);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        step();
        chk("mid_rst_stay_idle", int'(busy), 0);
        last_a = 0;
        run_seq(1'b1, 5, 3, 0, 1'b0, 1'b0);

        // randomized runs with random backpressure
        for (int i = 0; i < 30; i++) begin
            run_seq(1'($urandom), int'($urandom_range(0, (1 << WIDTH) - 1)),
                    int'($urandom_range(0, (1 << CNT_W) - 1)), 0, 1'b1, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_seq_gen.md
# parity_seq_gen

Sequence generator that drives a stream of WIDTH-bit values, all of one requested parity, toward the even/odd classifier. Each value carries its parity tag. It is the transmitting end of the parity-checking path: a start command programs the parity, the seed and the length, and the block emits the values under a valid/ready handshake. It then pulses `done`. Benches and the top-level datapath use it to feed the classifier's `a` input with known-parity traffic.

## Interface
- WIDTH, 4, data width of emitted values (≥2)
- CNT_W, 4, width of the length field
- clk  input  1  system clock; all state changes on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  command strobe; sampled only in IDLE
- want_even  input  1  1 = emit even values, 0 = emit odd values
- seed  input  WIDTH  starting value; LSB is overridden by parity
- count  input  CNT_W  number of values to emit (0 allowed)
- out_ready  input  1  downstream accepts current value
- out_valid  output  1  `a` holds a valid value
- a  output  WIDTH  emitted value
- is_even  output  1  parity tag, always equal to ~a[0]
- busy  output  1  high while not in IDLE
- done  output  1  one-cycle pulse at end of sequence

## Operation
- States:
  - IDLE: waits for a command.
  - EMIT: presents values.
  - DONE: pulses `done` for one cycle.
- IDLE, start=1, count≠0:
  - Latch remaining = count.
  - Load a = {seed[WIDTH-1:1], ~want_even}.
  - Go to EMIT.
- IDLE, start=1, count=0: go to DONE; no value is emitted.
- IDLE, start=0: hold.
- EMIT, out_valid & out_ready:
  - a <= a + 2, modulo 2^WIDTH. The LSB, and therefore the parity, is preserved.
  - remaining <= remaining − 1.
  - If remaining was 1: out_valid <= 0 and go to DONE.
- EMIT, out_ready=0: a, is_even, out_valid and remaining hold unchanged.
- DONE: done=1 for exactly this cycle, then unconditionally return to IDLE.
- start is ignored in EMIT and DONE; it is not queued. want_even, seed and count are sampled only with an accepted start.
- All outputs are registered.
- out_valid=1 iff state is EMIT.
- busy=1 iff state is not IDLE.
- done=1 iff state is DONE.
- is_even tracks ~a[0] in every cycle, including IDLE.
- Arithmetic: the +2 wraps silently. For WIDTH=4 the even sequence runs …12,14,0,2…; the odd sequence runs …13,15,1,3….
- Reset (any state, any cycle, including mid-handshake):
  - Next edge: state IDLE, a=0, is_even=1, out_valid=0, busy=0, done=0, remaining=0.
  - The in-progress sequence is abandoned.
- reset has priority over start.

## Timing
- Start accepted at edge N: out_valid, busy and the first `a` are visible after edge N.
- Latency from start to first value: 1 cycle.
- Throughput with out_ready held high: one value per cycle. With count=k, the values occupy the k cycles after edges N … N+k−1.
- Last handshake at edge M: after edge M, out_valid=0 and done=1. After edge M+1, done=0 and busy=0.
- The earliest next start is sampled at edge M+2.
- count=0 start at edge N: done=1 after edge N, busy=0 after edge N+1, and out_valid stays 0 throughout.
- Handshake completes only on an edge where out_valid=1 and out_ready=1. out_ready while out_valid=0 has no effect.
- `a` changes only on a completed handshake, on a command load, or on reset. It holds its last value in DONE and IDLE.

## Test plan
- Basic even sequence, ready held 1:
  - Stimulus: start, want_even=1, seed=5, count=3.
  - Response: a = 4, 6, 8 with is_even=1, valid for 3 consecutive cycles, then done pulses once and busy drops one cycle later.
- Odd sequence with wrap:
  - Stimulus: want_even=0, seed=13, count=4.
  - Response: a = 13, 15, 1, 3 with is_even=0, then done.
- Backpressure:
  - Stimulus: want_even=1, seed=0, count=2; out_ready low for 2 cycles after the first value appears.
  - Response: a=0 with out_valid=1 held stable for those cycles; then a=2 after the handshake; then done.
- Zero length:
  - Stimulus: start with count=0.
  - Response: done=1 the next cycle, out_valid never asserts, busy high exactly one cycle.
- Start while busy:
  - Stimulus: start a count=3 sequence; pulse start again with seed=9, want_even=0 during EMIT.
  - Response: the original three values are emitted unchanged, and no second sequence follows.
- Reset mid-operation:
  - Stimulus: assert reset after the second value of a count=5 sequence.
  - Response: next cycle a=0, is_even=1, out_valid=0, busy=0, done=0. A fresh start afterwards behaves exactly as in the first scenario.
